// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction memory address/data, ID back-pressure, EX redirect,
// and the IF/ID pipeline register contents presented to decode.
interface fetch_controller_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted,
    input  imem_instr, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted,
    output imem_instr, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, the IF/ID register and a one-entry skid
// buffer that catches the in-flight memory word while decode is stalled.
module fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.master bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] addr_r, addr_s;
  logic        inflight_v_r, inflight_v_s;
  logic [15:0] inflight_pc_r, inflight_pc_s;
  logic        skid_v_r, skid_v_s;
  logic [15:0] skid_instr_r, skid_instr_s;
  logic        if_valid_r, if_valid_s;
  logic [15:0] if_instr_r, if_instr_s;
  logic [15:0] if_pc_r, if_pc_s;
  logic        halted_r, halted_s;
  logic [15:0] data_s;

  // Next-state logic: redirect beats stall beats advance.
  always_comb begin
    state_s       = state_r;
    addr_s        = addr_r;
    inflight_v_s  = inflight_v_r;
    inflight_pc_s = inflight_pc_r;
    skid_v_s      = skid_v_r;
    skid_instr_s  = skid_instr_r;
    if_valid_s    = if_valid_r;
    if_instr_s    = if_instr_r;
    if_pc_s       = if_pc_r;
    data_s        = skid_v_r ? skid_instr_r : bus.imem_instr;

    if (bus.redirect_valid) begin
      addr_s       = {bus.redirect_pc[15:1], 1'b0};
      inflight_v_s = 1'b0;
      skid_v_s     = 1'b0;
      if_valid_s   = 1'b0;
      state_s      = ST_RUN;
    end else if (bus.stall) begin
      // Memory keeps reading the held address, so the in-flight word must be caught once.
      if (inflight_v_r && !skid_v_r) begin
        skid_instr_s = bus.imem_instr;
        skid_v_s     = 1'b1;
      end else begin
        skid_v_s = skid_v_r;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if_valid_s = inflight_v_r;
          if_instr_s = data_s;
          if_pc_s    = inflight_pc_r;
          skid_v_s   = 1'b0;
          if (inflight_v_r && (data_s[15:12] == HALT_OP)) begin
            state_s      = ST_HALTED;
            inflight_v_s = 1'b0;
          end else begin
            inflight_v_s  = 1'b1;
            inflight_pc_s = addr_r;
            addr_s        = addr_r + 16'd2;
          end
        end
        ST_HALTED: begin
          if_valid_s = 1'b0;
        end
        default: begin
          state_s    = ST_RUN;
          if_valid_s = 1'b0;
        end
      endcase
    end

    halted_s = (state_s == ST_HALTED);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r        <= RESET_PC;
      inflight_v_r  <= 1'b0;
      inflight_pc_r <= 16'h0000;
      skid_v_r      <= 1'b0;
      skid_instr_r  <= 16'h0000;
      if_valid_r    <= 1'b0;
      if_instr_r    <= 16'h0000;
      if_pc_r       <= 16'h0000;
      halted_r      <= 1'b0;
    end else begin
      addr_r        <= addr_s;
      inflight_v_r  <= inflight_v_s;
      inflight_pc_r <= inflight_pc_s;
      skid_v_r      <= skid_v_s;
      skid_instr_r  <= skid_instr_s;
      if_valid_r    <= if_valid_s;
      if_instr_r    <= if_instr_s;
      if_pc_r       <= if_pc_s;
      halted_r      <= halted_s;
    end
  end

  assign bus.imem_addr = addr_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.if_instr  = if_instr_r;
  assign bus.if_pc     = if_pc_r;
  assign bus.halted    = halted_r;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the 5-stage pipelined datapath. Owns the program counter, drives the address port of `InstructionMemory` (1-cycle registered read), and owns the IF/ID pipeline register. Handles ID stalls via a one-entry skid buffer, EX-stage branch/jump redirects with flush, and a halt opcode that parks fetch until redirected.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `HALT_OP`, 4'hF: value of `instr[15:12]` that halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  16  registered address to `InstructionMemory.ReadAddress`.
- `imem_instr`  in  16  `InstructionMemory.Instruction`; equals M[address sampled at previous posedge].
- `stall`  in  1  ID cannot accept; hold IF/ID.
- `redirect_valid`  in  1  one-cycle pulse from EX: taken branch/jump.
- `redirect_pc`  in  16  redirect target; bit 0 forced to 0.
- `if_valid`  out  1  IF/ID holds a valid instruction.
- `if_instr`  out  16  IF/ID instruction.
- `if_pc`  out  16  address of `if_instr`.
- `halted`  out  1  state == HALTED.

## Operation
- Internal state: `inflight_v`, `inflight_pc` (address whose data is on `imem_instr`), `skid_v`, `skid_instr`, FSM {RUN, HALTED}.
- Reset (rst=1 at posedge): `imem_addr`=RESET_PC, `inflight_v`=0, `skid_v`=0, `if_valid`=0, `if_instr`=16'h0000, `if_pc`=16'h0000, state=RUN, `halted`=0.
- Edge priority, rst=0: redirect > stall > advance.
- Redirect (any state): `imem_addr`<=`{redirect_pc[15:1],1'b0}`; `inflight_v`<=0; `skid_v`<=0; `if_valid`<=0; state<=RUN. Stall ignored this edge.
- Stall, no redirect: IF/ID, `imem_addr`, `inflight_*`, state all hold. If `inflight_v` && !`skid_v`: `skid_instr`<=`imem_instr`, `skid_v`<=1. Later stall edges do not overwrite the skid.
- Advance (RUN, no stall, no redirect): let D = `skid_v` ? `skid_instr` : `imem_instr`. `if_valid`<=`inflight_v`; `if_instr`<=D; `if_pc`<=`inflight_pc`; `skid_v`<=0.
  - If `inflight_v` && D[15:12]==HALT_OP: state<=HALTED; `inflight_v`<=0; `imem_addr` holds.
  - Else: `inflight_v`<=1; `inflight_pc`<=`imem_addr`; `imem_addr`<=`imem_addr`+2.
- HALTED, no redirect: `imem_addr` and `inflight_v`=0 hold. The halt instruction stays in IF/ID until a non-stall edge, which clears `if_valid`. `if_valid` then stays 0.
- Arithmetic: `imem_addr`+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- Reset mid-stall, mid-redirect or while HALTED: reset wins and all state returns to reset values.

## Timing
- First `if_valid`=1 at the 2nd posedge with rst=0, carrying `if_pc`=RESET_PC. After that, one instruction per cycle when there is no stall.
- Redirect penalty: `if_valid`=0 for the 2 cycles after the redirect edge. The target instruction appears in IF/ID at the 2nd following non-stall edge.
- Stall of N cycles: IF/ID is frozen for N cycles. No instruction is lost or duplicated. The sequence resumes on the first non-stall edge.
- `halted` rises on the edge that loads the halt instruction into IF/ID. It falls on a redirect edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset release, M[0..6]=A0,A1,A2,A3, no stall: `if_pc` 0000,0002,0004,0006 on consecutive cycles starting at the 2nd edge after rst falls, with `if_instr` = A0..A3.
- Stall for 3 cycles while `if_pc`=0002: `if_pc` and `if_instr` hold for 3 cycles. The next values are 0004/A2, then 0006/A3, with no skips and no repeats.
- `redirect_valid` with `redirect_pc`=0041 while streaming: target is forced to 0040. `if_valid`=0 for 2 cycles, then `if_pc`=0040 and 0042 carry M[0040] and M[0042].
- Redirect and stall asserted on the same edge: redirect wins, `if_valid`=0, and fetch resumes at the target as in the previous case.
- M[0006]=F000: `halted`=1 when `if_pc`=0006. `imem_addr` stays 0008 and `if_valid` drops after one cycle. A later redirect to 0000 clears `halted` and refetches A0.
- Start at `redirect_pc`=FFFC: `if_pc` sequence is FFFC, FFFE, 0000, 0002 (wrap). Then assert `rst` during a stall: all outputs return to their reset values on the next edge.
